// File: rtl/lcd_pkg.sv
// Shared types, instruction masks and DDRAM address helpers for the HD44780 responder.
package lcd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_CLEAR,
    ST_BUSY
  } lcd_state_e;

  localparam logic [7:0] INSTR_CLR   = 8'h01;
  localparam logic [7:0] INSTR_HOME  = 8'h02;
  localparam logic [7:0] INSTR_ENTRY = 8'h04;
  localparam logic [7:0] INSTR_DISP  = 8'h08;
  localparam logic [7:0] INSTR_SHIFT = 8'h10;
  localparam logic [7:0] INSTR_FUNC  = 8'h20;
  localparam logic [7:0] INSTR_CGRAM = 8'h40;
  localparam logic [7:0] INSTR_DDRAM = 8'h80;

  localparam logic [6:0] LINE1_BASE  = 7'h00;
  localparam logic [6:0] LINE1_END   = 7'h27;
  localparam logic [6:0] LINE2_BASE  = 7'h40;
  localparam logic [6:0] LINE2_END   = 7'h67;
  localparam int         VISIBLE_LEN = 16;
  localparam logic [7:0] BLANK_CHAR  = 8'h20;

  // Addresses past a line end (0x28-0x3F, 0x68-0x7F) resolve to 0x40 going up, 0x00 going down.
  function automatic logic [6:0] ac_step(input logic [6:0] ac, input logic inc);
    logic [6:0] nxt;
    logic       off_map;
    off_map = (ac > LINE2_END) || ((ac > LINE1_END) && (ac < LINE2_BASE));
    if (inc) begin
      if (ac == LINE2_END)                  nxt = LINE1_BASE;
      else if (off_map || ac == LINE1_END)  nxt = LINE2_BASE;
      else                                  nxt = ac + 7'd1;
    end else begin
      if (ac == LINE1_BASE)                 nxt = LINE2_END;
      else if (ac == LINE2_BASE)            nxt = LINE1_END;
      else if (off_map)                     nxt = LINE1_BASE;
      else                                  nxt = ac - 7'd1;
    end
    return nxt;
  endfunction

  function automatic logic ac_visible(input logic [6:0] ac);
    return (ac[6:4] == 3'b000) || (ac[6:4] == 3'b100);
  endfunction

  // Line 1 columns map to cells 0-15, line 2 columns to cells 16-31.
  function automatic logic [4:0] ac_cell(input logic [6:0] ac);
    return {ac[6], ac[3:0]};
  endfunction

endpackage

// File: rtl/lcd_bus_sync.sv
// Bus input synchronizer with EN falling-edge detection.
// LCD_RESP_ENPW_CHECK_EN adds an EN high-width check flagging short strobes.
module lcd_bus_sync #(
  parameter int SYNC_STAGES = 2
`ifdef LCD_RESP_ENPW_CHECK_EN
  , parameter int MIN_EN_HIGH = 10
`endif
) (
  input  logic       iCLK,
  input  logic       iRST_N,
  input  logic [7:0] lcd_data,
  input  logic       lcd_rs,
  input  logic       lcd_rw,
  input  logic       lcd_en,
  output logic [7:0] data_o,
  output logic       rs_o,
  output logic       rw_o,
  output logic       fall_o,
  output logic       short_o
);

  // {EN, RW, RS, DATA} travel together so every field comes from the same stage.
  logic [SYNC_STAGES-1:0][10:0] sync_q, sync_d;
  logic                         en_prev_q, en_prev_d;
  logic                         en_s;

  always_comb begin
    sync_d    = sync_q;
    sync_d[0] = {lcd_en, lcd_rw, lcd_rs, lcd_data};
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      sync_q    <= '0;
      en_prev_q <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      en_prev_q <= en_prev_d;
    end
  end

  assign en_s      = sync_q[SYNC_STAGES-1][10];
  assign en_prev_d = en_s;
  assign rw_o      = sync_q[SYNC_STAGES-1][9];
  assign rs_o      = sync_q[SYNC_STAGES-1][8];
  assign data_o    = sync_q[SYNC_STAGES-1][7:0];
  assign fall_o    = en_prev_q & ~en_s;

`ifdef LCD_RESP_ENPW_CHECK_EN
  localparam int HW = $clog2(MIN_EN_HIGH + 1) + 1;

  logic [HW-1:0] hi_cnt_q, hi_cnt_d;

  // Saturating count of consecutive synced-high cycles; cleared while EN is low.
  always_comb begin
    hi_cnt_d = '0;
    if (en_s) begin
      hi_cnt_d = (hi_cnt_q >= HW'(MIN_EN_HIGH)) ? hi_cnt_q : hi_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) hi_cnt_q <= '0;
    else         hi_cnt_q <= hi_cnt_d;
  end

  assign short_o = fall_o && (hi_cnt_q < HW'(MIN_EN_HIGH));
`else
  assign short_o = 1'b0;
`endif

endmodule

// File: rtl/lcd_hd44780_responder.sv
// Panel-side HD44780 responder: decodes the write-only LCD bus into a 2x16 DDRAM image.
// Optional EN width checking is enabled with LCD_RESP_ENPW_CHECK_EN.
module lcd_hd44780_responder
  import lcd_pkg::*;
#(
  parameter int SYNC_STAGES  = 2,
  parameter int BUSY_CYCLES  = 2000,
  parameter int CLEAR_CYCLES = 76500,
  parameter int MIN_EN_HIGH  = 10
) (
  input  logic       iCLK,
  input  logic       iRST_N,
  input  logic [7:0] LCD_DATA,
  input  logic       LCD_RS,
  input  logic       LCD_RW,
  input  logic       LCD_EN,
  input  logic [4:0] iRdIdx,
  output logic [7:0] oRdChar,
  output logic [6:0] oAC,
  output logic       oIncMode,
  output logic       oDisplayOn,
  output logic       oCursorOn,
  output logic       oBlinkOn,
  output logic       oBusy,
  output logic       oWrStrobe,
  output logic       oCmdStrobe,
  output logic       oOverrun,
  output logic       oTimingErr
);

  localparam int NCELLS  = 2 * VISIBLE_LEN;
  // Sized to hold the longest cycle count this instance is configured with.
  localparam int CNT_MAX = (CLEAR_CYCLES > BUSY_CYCLES) ? CLEAR_CYCLES : BUSY_CYCLES;
  localparam int CNT_W   = $clog2(((CNT_MAX > MIN_EN_HIGH) ? CNT_MAX : MIN_EN_HIGH) + 1);

  logic [7:0] bus_data;
  logic       bus_rs, bus_rw, bus_fall, bus_short;

  lcd_bus_sync #(
    .SYNC_STAGES(SYNC_STAGES)
`ifdef LCD_RESP_ENPW_CHECK_EN
    , .MIN_EN_HIGH(MIN_EN_HIGH)
`endif
  ) u_bus_sync (
    .iCLK    (iCLK),
    .iRST_N  (iRST_N),
    .lcd_data(LCD_DATA),
    .lcd_rs  (LCD_RS),
    .lcd_rw  (LCD_RW),
    .lcd_en  (LCD_EN),
    .data_o  (bus_data),
    .rs_o    (bus_rs),
    .rw_o    (bus_rw),
    .fall_o  (bus_fall),
    .short_o (bus_short)
  );

  lcd_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]       clr_idx_q, clr_idx_d;
  logic [7:0]       cmd_q, cmd_d;
  logic             rs_q, rs_d;
  logic [6:0]       ac_q, ac_d;
  logic             inc_q, inc_d;
  logic             disp_q, disp_d, cur_q, cur_d, blink_q, blink_d;
  logic             wr_stb_q, wr_stb_d, cmd_stb_q, cmd_stb_d;
  logic             ovr_q, ovr_d, terr_q, terr_d;
  logic [7:0]       rd_char_q, rd_char_d;

  logic [7:0]       ddram_q [NCELLS];
  logic             ram_we;
  logic [4:0]       ram_addr;
  logic [7:0]       ram_wdata;

  logic             xfer_ok;
  assign xfer_ok = bus_fall & ~bus_short;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    clr_idx_d = clr_idx_q;
    cmd_d     = cmd_q;
    rs_d      = rs_q;
    ac_d      = ac_q;
    inc_d     = inc_q;
    disp_d    = disp_q;
    cur_d     = cur_q;
    blink_d   = blink_q;
    wr_stb_d  = 1'b0;
    cmd_stb_d = 1'b0;
    ovr_d     = 1'b0;
    terr_d    = bus_short;
    ram_we    = 1'b0;
    ram_addr  = clr_idx_q;
    ram_wdata = BLANK_CHAR;

    case (state_q)
      ST_IDLE: begin
        if (xfer_ok) begin
          if (bus_rw) begin
            ovr_d = 1'b1;
          end else if (!bus_rs && bus_data == INSTR_CLR) begin
            state_d   = ST_CLEAR;
            clr_idx_d = '0;
            cmd_stb_d = 1'b1;
          end else begin
            state_d = ST_EXEC;
            cmd_d   = bus_data;
            rs_d    = bus_rs;
          end
        end
      end

      ST_EXEC: begin
        state_d = ST_BUSY;
        cnt_d   = CNT_W'(BUSY_CYCLES);
        if (rs_q) begin
          wr_stb_d  = 1'b1;
          ram_we    = ac_visible(ac_q);
          ram_addr  = ac_cell(ac_q);
          ram_wdata = cmd_q;
          ac_d      = ac_step(ac_q, inc_q);
        end else begin
          cmd_stb_d = 1'b1;
          // Highest set bit selects the instruction.
          if ((cmd_q & INSTR_DDRAM) != 8'h00) begin
            ac_d = cmd_q[6:0];
          end else if ((cmd_q & (INSTR_CGRAM | INSTR_FUNC)) != 8'h00) begin
            ac_d = ac_q;
          end else if ((cmd_q & INSTR_SHIFT) != 8'h00) begin
            if (!cmd_q[3]) ac_d = ac_step(ac_q, cmd_q[2]);
          end else if ((cmd_q & INSTR_DISP) != 8'h00) begin
            disp_d  = cmd_q[2];
            cur_d   = cmd_q[1];
            blink_d = cmd_q[0];
          end else if ((cmd_q & INSTR_ENTRY) != 8'h00) begin
            inc_d = cmd_q[1];
          end else if ((cmd_q & INSTR_HOME) != 8'h00) begin
            ac_d = LINE1_BASE;
          end
        end
      end

      ST_CLEAR: begin
        ram_we    = 1'b1;
        ram_addr  = clr_idx_q;
        clr_idx_d = clr_idx_q + 5'd1;
        if (clr_idx_q == 5'(NCELLS - 1)) begin
          ac_d    = LINE1_BASE;
          inc_d   = 1'b1;
          cnt_d   = CNT_W'(CLEAR_CYCLES - NCELLS);
          state_d = ST_BUSY;
        end
      end

      ST_BUSY: begin
        if (cnt_q == '0) state_d = ST_IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end

      default: state_d = ST_IDLE;
    endcase

    if (state_q != ST_IDLE && xfer_ok) ovr_d = 1'b1;

    rd_char_d = ddram_q[iRdIdx];
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      clr_idx_q <= '0;
      cmd_q     <= '0;
      rs_q      <= 1'b0;
      ac_q      <= LINE1_BASE;
      inc_q     <= 1'b1;
      disp_q    <= 1'b0;
      cur_q     <= 1'b0;
      blink_q   <= 1'b0;
      wr_stb_q  <= 1'b0;
      cmd_stb_q <= 1'b0;
      ovr_q     <= 1'b0;
      terr_q    <= 1'b0;
      rd_char_q <= BLANK_CHAR;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      clr_idx_q <= clr_idx_d;
      cmd_q     <= cmd_d;
      rs_q      <= rs_d;
      ac_q      <= ac_d;
      inc_q     <= inc_d;
      disp_q    <= disp_d;
      cur_q     <= cur_d;
      blink_q   <= blink_d;
      wr_stb_q  <= wr_stb_d;
      cmd_stb_q <= cmd_stb_d;
      ovr_q     <= ovr_d;
      terr_q    <= terr_d;
      rd_char_q <= rd_char_d;
    end
  end

  // Flop array rather than block RAM: reset must blank every cell at once.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      for (int i = 0; i < NCELLS; i++) ddram_q[i] <= BLANK_CHAR;
    end else if (ram_we) begin
      ddram_q[ram_addr] <= ram_wdata;
    end
  end

  assign oRdChar    = rd_char_q;
  assign oAC        = ac_q;
  assign oIncMode   = inc_q;
  assign oDisplayOn = disp_q;
  assign oCursorOn  = cur_q;
  assign oBlinkOn   = blink_q;
  assign oBusy      = (state_q != ST_IDLE);
  assign oWrStrobe  = wr_stb_q;
  assign oCmdStrobe = cmd_stb_q;
  assign oOverrun   = ovr_q;
  assign oTimingErr = terr_q;

endmodule

// File: tb/tb_lcd_hd44780_responder.sv
// Self-checking bench: table of directed bus transfers, corner-case sequences and a
// randomized phase compared against a behavioural DDRAM/address-counter model.
module tb_lcd_hd44780_responder;

  localparam int BUSY_C  = 200;
  localparam int CLEAR_C = 400;

  logic       iCLK = 1'b0;
  logic       iRST_N = 1'b0;
  logic [7:0] LCD_DATA = 8'h00;
  logic       LCD_RS = 1'b0, LCD_RW = 1'b0, LCD_EN = 1'b0;
  logic [4:0] iRdIdx = 5'd0;
  logic [7:0] oRdChar;
  logic [6:0] oAC;
  logic       oIncMode, oDisplayOn, oCursorOn, oBlinkOn, oBusy;
  logic       oWrStrobe, oCmdStrobe, oOverrun, oTimingErr;

  lcd_hd44780_responder #(
    .SYNC_STAGES (2),
    .BUSY_CYCLES (BUSY_C),
    .CLEAR_CYCLES(CLEAR_C),
    .MIN_EN_HIGH (10)
  ) dut (
    .iCLK(iCLK), .iRST_N(iRST_N), .LCD_DATA(LCD_DATA), .LCD_RS(LCD_RS),
    .LCD_RW(LCD_RW), .LCD_EN(LCD_EN), .iRdIdx(iRdIdx), .oRdChar(oRdChar),
    .oAC(oAC), .oIncMode(oIncMode), .oDisplayOn(oDisplayOn), .oCursorOn(oCursorOn),
    .oBlinkOn(oBlinkOn), .oBusy(oBusy), .oWrStrobe(oWrStrobe), .oCmdStrobe(oCmdStrobe),
    .oOverrun(oOverrun), .oTimingErr(oTimingErr)
  );

  always #5 iCLK = ~iCLK;

  int vec_cnt = 0;
  int miscompares = 0;
  int wr_cnt = 0, cmd_cnt = 0, ovr_cnt = 0, terr_cnt = 0;
  int exp_wr = 0, exp_cmd = 0;

  always @(negedge iCLK) begin
    if (oWrStrobe)  wr_cnt++;
    if (oCmdStrobe) cmd_cnt++;
    if (oOverrun)   ovr_cnt++;
    if (oTimingErr) terr_cnt++;
  end

  // Behavioural model: display as two lines of 16 characters plus a cursor address.
  logic [7:0] m_ram [32];
  logic [6:0] m_ac;
  logic       m_inc;
  logic [2:0] m_dcb;

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_ram[i] = 8'h20;
    m_ac = 7'h00; m_inc = 1'b1; m_dcb = 3'b000;
  endtask

  function automatic logic [6:0] m_step(input logic [6:0] a, input logic up);
    int v;
    v = int'(a);
    if (up) begin
      if (v < 'h27 || (v >= 'h40 && v < 'h67)) return 7'(v + 1);
      if (v == 'h67) return 7'h00;
      return 7'h40;
    end else begin
      if ((v > 0 && v <= 'h27) || (v > 'h40 && v <= 'h67)) return 7'(v - 1);
      if (v == 0) return 7'h67;
      if (v == 'h40) return 7'h27;
      return 7'h00;
    end
  endfunction

  task automatic model_apply(input logic rs, input logic [7:0] d);
    int line, col;
    if (rs) begin
      line = (m_ac >= 7'h40) ? 1 : 0;
      col  = int'(m_ac) - line * 'h40;
      if (col >= 0 && col < 16) m_ram[line * 16 + col] = d;
      m_ac = m_step(m_ac, m_inc);
      exp_wr++;
    end else begin
      exp_cmd++;
      if (d[7])             m_ac = d[6:0];
      else if (d[6] | d[5]) m_ac = m_ac;
      else if (d[4])        begin if (!d[3]) m_ac = m_step(m_ac, d[2]); end
      else if (d[3])        m_dcb = d[2:0];
      else if (d[2])        m_inc = d[1];
      else if (d[1])        m_ac = 7'h00;
      else if (d[0])        begin for (int i = 0; i < 32; i++) m_ram[i] = 8'h20; m_ac = 7'h00; m_inc = 1'b1; end
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    vec_cnt++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge iCLK);
    #1;
  endtask

  // Raw bus cycle: set up fields, hold EN high for hi cycles, drop it, let it propagate.
  task automatic xfer(input logic rs, input logic rw, input logic [7:0] d, input int hi);
    tick(1);
    LCD_RS = rs; LCD_RW = rw; LCD_DATA = d; LCD_EN = 1'b0;
    tick(1);
    LCD_EN = 1'b1;
    tick(hi);
    LCD_EN = 1'b0;
    tick(3);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    tick(2);
    while (oBusy && n < 3000) begin tick(1); n++; end
    if (oBusy) begin
      vec_cnt++; miscompares++;
      $display("FAIL idle_timeout: oBusy still 1 after %0d cycles, required 0", n);
    end
  endtask

  task automatic do_xfer(input logic rs, input logic [7:0] d);
    xfer(rs, 1'b0, d, 12);
    model_apply(rs, d);
    wait_idle();
  endtask

  task automatic read_cell(input int idx, output logic [7:0] v);
    iRdIdx = 5'(idx);
    tick(1);
    v = oRdChar;
  endtask

  task automatic check_state(input string tag);
    check({tag, "_ac"},  int'(oAC), int'(m_ac));
    check({tag, "_inc"}, int'(oIncMode), int'(m_inc));
    check({tag, "_dcb"}, int'({oDisplayOn, oCursorOn, oBlinkOn}), int'(m_dcb));
  endtask

  typedef struct {
    logic       rs;
    logic [7:0] data;
    logic [6:0] exp_ac;
    logic       exp_inc;
    logic [2:0] exp_dcb;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic rs, input logic [7:0] d, input logic [6:0] ac,
                     input logic inc, input logic [2:0] dcb);
    vec_t v;
    v.rs = rs; v.data = d; v.exp_ac = ac; v.exp_inc = inc; v.exp_dcb = dcb;
    tbl.push_back(v);
  endtask

  initial begin
    logic [7:0] ch;
    logic       rs;
    logic [7:0] d;
    int         cat, idx;

    model_reset();

    // Reset values.
    tick(4);
    check("rst_ac", int'(oAC), 0);
    check("rst_inc", int'(oIncMode), 1);
    check("rst_dcb", int'({oDisplayOn, oCursorOn, oBlinkOn}), 0);
    check("rst_busy", int'(oBusy), 0);
    check("rst_rdchar", int'(oRdChar), 'h20);
    iRST_N = 1'b1;
    tick(2);
    check("rst_strobes", int'({oWrStrobe, oCmdStrobe, oOverrun, oTimingErr}), 0);

    // Directed table: init sequence, line writes, off-screen write, decrement wrap.
    add(0, 8'h38, 7'h00, 1, 3'b000);
    add(0, 8'h0C, 7'h00, 1, 3'b100);
    add(0, 8'h01, 7'h00, 1, 3'b100);
    add(0, 8'h06, 7'h00, 1, 3'b100);
    add(0, 8'h80, 7'h00, 1, 3'b100);
    add(1, 8'h41, 7'h01, 1, 3'b100);
    add(0, 8'hC0, 7'h40, 1, 3'b100);
    for (int i = 0; i < 16; i++) add(1, 8'(8'h30 + i), 7'(7'h41 + i), 1, 3'b100);
    add(0, 8'hA7, 7'h27, 1, 3'b100);
    add(1, 8'h58, 7'h40, 1, 3'b100);
    add(0, 8'h04, 7'h40, 0, 3'b100);
    add(0, 8'h80, 7'h00, 0, 3'b100);
    add(1, 8'h59, 7'h67, 0, 3'b100);

    for (int i = 0; i < tbl.size(); i++) begin
      do_xfer(tbl[i].rs, tbl[i].data);
      $display("tbl %0d rs=%0d data=0x%02h ac=0x%02h inc=%0d dcb=%0d", i, tbl[i].rs,
               tbl[i].data, oAC, oIncMode, {oDisplayOn, oCursorOn, oBlinkOn});
      check($sformatf("tbl%0d_ac", i), int'(oAC), int'(tbl[i].exp_ac));
      check($sformatf("tbl%0d_inc", i), int'(oIncMode), int'(tbl[i].exp_inc));
      check($sformatf("tbl%0d_dcb", i), int'({oDisplayOn, oCursorOn, oBlinkOn}), int'(tbl[i].exp_dcb));
      if (i == 4) begin
        check("init_cmd_strobes", cmd_cnt, 5);
        for (int c = 0; c < 32; c++) begin
          read_cell(c, ch);
          check($sformatf("init_cell%0d", c), int'(ch), 'h20);
        end
      end
    end
    for (int c = 0; c < 32; c++) begin
      read_cell(c, ch);
      check($sformatf("tbl_cell%0d", c), int'(ch),
            (c == 0) ? 'h59 : (c >= 16) ? ('h30 + c - 16) : 'h20);
    end
    check("tbl_wr_strobes", wr_cnt, 19);

    // Second strobe 100 cycles into the busy window is dropped.
    do_xfer(0, 8'h06);
    do_xfer(0, 8'h83);
    xfer(1, 1'b0, 8'h61, 12);
    model_apply(1, 8'h61);
    tick(80);
    xfer(1, 1'b0, 8'h62, 12);
    wait_idle();
    $display("overrun seq ac=0x%02h overruns=%0d", oAC, ovr_cnt);
    check("ovr_busy_count", ovr_cnt, 1);
    check_state("ovr");
    read_cell(3, ch); check("ovr_cell3", int'(ch), 'h61);
    read_cell(4, ch); check("ovr_cell4", int'(ch), 'h20);

    // Read cycle while idle is refused.
    xfer(0, 1'b1, 8'h85, 12);
    tick(2);
    $display("rw=1 seq busy=%0d overruns=%0d", oBusy, ovr_cnt);
    check("ovr_rw_count", ovr_cnt, 2);
    check("ovr_rw_busy", int'(oBusy), 0);
    check_state("ovr_rw");

    // Reset ten cycles into a clear.
    do_xfer(0, 8'h85);
    do_xfer(1, 8'h41);
    read_cell(5, ch); check("pre_clr_cell5", int'(ch), 'h41);
    xfer(0, 1'b0, 8'h01, 12);
    exp_cmd++;
    tick(10);
    check("clr_busy", int'(oBusy), 1);
    iRST_N = 1'b0;
    tick(2);
    $display("reset mid-clear busy=%0d ac=0x%02h", oBusy, oAC);
    check("midclr_busy", int'(oBusy), 0);
    check("midclr_ac", int'(oAC), 0);
    iRST_N = 1'b1;
    model_reset();
    tick(2);
    read_cell(5, ch); check("midclr_cell5", int'(ch), 'h20);
    check_state("midclr");

    // Randomized transfers against the model.
    for (int n = 0; n < 40; n++) begin
      rs = 1'($urandom_range(0, 1));
      if (rs) begin
        d = 8'($urandom_range('h21, 'h7E));
      end else begin
        cat = $urandom_range(0, 7);
        case (cat)
          0: d = 8'h80 | 8'($urandom_range(0, 127));
          1: d = 8'h40 | 8'($urandom_range(0, 63));
          2: d = 8'h20 | 8'($urandom_range(0, 31));
          3: d = 8'h10 | 8'($urandom_range(0, 15));
          4: d = 8'h08 | 8'($urandom_range(0, 7));
          5: d = 8'h04 | 8'($urandom_range(0, 3));
          6: d = 8'h02 | 8'($urandom_range(0, 1));
          default: d = ($urandom_range(0, 3) == 0) ? 8'h01 : 8'h00;
        endcase
      end
      do_xfer(rs, d);
      idx = $urandom_range(0, 31);
      read_cell(idx, ch);
      $display("rnd %0d rs=%0d data=0x%02h ac=0x%02h cell%0d=0x%02h", n, rs, d, oAC, idx, ch);
      check_state($sformatf("rnd%0d", n));
      check($sformatf("rnd%0d_cell%0d", n, idx), int'(ch), int'(m_ram[idx]));
    end
    for (int c = 0; c < 32; c++) begin
      read_cell(c, ch);
      check($sformatf("rnd_final_cell%0d", c), int'(ch), int'(m_ram[c]));
    end

`ifdef LCD_RESP_ENPW_CHECK_EN
    // Too-short EN strobe is flagged and dropped.
    do_xfer(0, 8'h80);
    xfer(1, 1'b0, 8'h41, 4);
    tick(1);
    $display("short strobe busy=%0d timing_errs=%0d", oBusy, terr_cnt);
    check("terr_count", terr_cnt, 1);
    check("terr_busy", int'(oBusy), 0);
    read_cell(0, ch); check("terr_cell0", int'(ch), int'(m_ram[0]));
    check_state("terr");
`else
    check("terr_never", terr_cnt, 0);
`endif

    check("total_wr_strobes", wr_cnt, exp_wr);
    check("total_cmd_strobes", cmd_cnt, exp_cmd);
    check("total_overruns", ovr_cnt, 2);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
    $finish;
  end

endmodule

// File: doc/lcd_hd44780_responder.md
Name: lcd_hd44780_responder

Overview:
Synthesizable HD44780-compatible panel-side responder: the receiving end of the team's write-only character-LCD bus (LCD_DATA/RS/RW/EN).
- Latches transfers on the EN falling edge, decodes the command subset, maintains a 2x16 visible DDRAM image and address counter, and models the busy window.
- Used as an on-chip loopback/verification target for the LCD driver and as a character-buffer source for mirroring the display, e.g. to VGA.

Parameters:
SYNC_STAGES, 2, synchronizer depth on all bus inputs (same depth for all so they stay aligned)
BUSY_CYCLES, 2000, iCLK cycles busy after any non-clear transfer (40 us @ 50 MHz)
CLEAR_CYCLES, 76500, iCLK cycles busy after clear display (1.53 ms @ 50 MHz)
MIN_EN_HIGH, 10, minimum EN high width in iCLK cycles (used only with optional feature)

Ports:
iCLK  in  1  clock
iRST_N  in  1  reset, asynchronous, active-low
LCD_DATA  in  8  bus data/command byte
LCD_RS  in  1  1=data, 0=instruction
LCD_RW  in  1  0=write; 1=read (unsupported, ignored)
LCD_EN  in  1  enable strobe
iRdIdx  in  5  display cell index: 0-15 line 1, 16-31 line 2
oRdChar  out  8  DDRAM[iRdIdx], registered, 1-cycle latency
oAC  out  7  address counter
oIncMode  out  1  entry mode I/D
oDisplayOn, oCursorOn, oBlinkOn  out  1 each  display control D/C/B
oBusy  out  1  busy flag
oWrStrobe  out  1  1-cycle pulse on accepted data write (including discarded off-screen writes)
oCmdStrobe  out  1  1-cycle pulse on accepted instruction
oOverrun  out  1  1-cycle pulse: transfer ignored because busy or RW=1
oTimingErr  out  1  1-cycle pulse: EN high width too short (optional feature)

Behaviour:
- Reset values:
  - DDRAM all 0x20; oRdChar 0x20; oAC 0; oIncMode 1; D/C/B 0.
  - oBusy and all strobes 0; state IDLE.
- Input synchronization and edge detection:
  - All four bus inputs pass through SYNC_STAGES flops.
  - Falling edge = synced EN 1->0; RS/RW/DATA are taken from the same synced stage as EN.
- States:
  - IDLE: on falling edge with RW=0 -> EXEC (or CLEAR for 0x01). With RW=1 -> pulse oOverrun, stay IDLE.
  - EXEC: one cycle. Apply the data write or instruction, pulse oWrStrobe/oCmdStrobe, load busy counter = BUSY_CYCLES -> BUSY.
  - CLEAR: write 0x20 to cells 0..31, one per cycle (32 cycles). Then AC=0, I/D=1, load counter = CLEAR_CYCLES-32 -> BUSY. oBusy=1 throughout.
  - BUSY: decrement counter; at 0 -> IDLE. Any falling edge here pulses oOverrun and is dropped, with no state change.
- oBusy=1 in EXEC/CLEAR/BUSY.
- Instruction decode (highest set bit wins):
  - 0x80|a: AC=a[6:0].
  - 0x40-0x7F: CGRAM address; accepted, no effect.
  - 0x20-0x3F: function set; accepted, no effect.
  - 0x10-0x1F: cursor shift. Bit3=0 moves AC by bit2 (1=+1, 0=-1) with wrap rules; bit3=1 (display shift) has no effect.
  - 0x08-0x0F: D=b2, C=b1, B=b0.
  - 0x04-0x07: I/D=b1; S ignored.
  - 0x02/0x03: AC=0.
  - 0x01: clear.
  - 0x00: accepted no-op.
- Data write:
  - Store at cell(AC) if AC in 0x00-0x0F (cell=AC) or 0x40-0x4F (cell=16+AC-0x40).
  - Other valid addresses discard the data; AC still steps.
  - Then step AC per I/D.
- AC stepping and wrap:
  - Increment: 0x27 -> 0x40, 0x67 -> 0x00.
  - Decrement: 0x00 -> 0x67, 0x40 -> 0x27.
  - Set-address values in 0x28-0x3F or 0x68-0x7F are loaded as given; the next step resolves them to 0x40 (inc) or 0x00 (dec).
- Read port: oRdChar <= DDRAM[iRdIdx] every cycle, independent of state. During CLEAR it may show partially cleared contents.
- Async reset mid-operation (including mid-CLEAR) returns to full reset values immediately.

Optional Feature:
Macro LCD_RESP_ENPW_CHECK_EN.
- Defined: a counter measures synced EN high time. A falling edge after fewer than MIN_EN_HIGH high cycles pulses oTimingErr and drops the transfer; no state change, busy not set.
- Undefined: no width counter; oTimingErr tied 0.

Decomposition:
- Package lcd_pkg:
  - State enum.
  - Instruction mask constants: CLR, HOME, ENTRY, DISP, SHIFT, FUNC, CGRAM, DDRAM.
  - LINE1_BASE 0x00, LINE1_END 0x27, LINE2_BASE 0x40, LINE2_END 0x67, VISIBLE_LEN 16, BLANK_CHAR 0x20.
- Sub-module lcd_bus_sync: synchronizer plus EN falling-edge/width detector. Outputs aligned RS/RW/DATA and a fall pulse.

Test Plan:
- Init sequence 0x38,0x0C,0x01,0x06,0x80 with proper gaps -> oDisplayOn=1, oCursorOn=0, oIncMode=1, oAC=0, all cells 0x20, five oCmdStrobe pulses.
- Data 0x41 at AC=0, then 0xC0 plus 16 bytes 0x30..0x3F -> cell0=0x41, cells16..31=0x30..0x3F, oAC=0x50.
- 0xA7 then data 0x58 -> no visible cell changes, oAC=0x40. Then 0x04, 0x80, data 0x59 -> cell0=0x59, oAC=0x67.
- Second EN pulse 100 cycles after the first -> oOverrun pulse, DDRAM/AC unchanged. Same with RW=1 while idle.
- Assert iRST_N=0 ten cycles into CLEAR after writing 0x41 to cell5 -> cell5=0x20, oBusy=0, oAC=0.
- With LCD_RESP_ENPW_CHECK_EN, EN high 4 cycles with data 0x41 -> oTimingErr pulse, cell unchanged, oBusy=0.
